// File: rtl/rgb565_pkg.sv
// rgb565_pkg: shared pixel types and the RGB565 -> RGB888 expansion used by
// the pixel serializer.
//   rgb565_t  : one packed 16-bit pixel, {r5, g6, b5}
//   rgb888_t  : one packed 24-bit pixel, {R8, G8, B8}
//   expand565 : widens each field by replicating its MSBs into the new LSBs,
//               so full-scale 5/6-bit values map to full-scale 8-bit values.
package rgb565_pkg;

    localparam int WORD_W  = 32;
    localparam int PIXEL_W = 24;

    typedef logic [15:0] rgb565_t;
    typedef logic [23:0] rgb888_t;

    function automatic rgb888_t expand565(input rgb565_t p);
        return {p[15:11], p[15:13],   // R8
                p[10:5],  p[10:9],    // G8
                p[4:0],   p[4:2]};    // B8
    endfunction

endpackage

// File: rtl/word_fifo.sv
// word_fifo: single-clock FIFO of DEPTH x 32-bit words.
//   clock  : clock for all state
//   reset  : asynchronous, active-high; empties the FIFO
//   push   : write din this cycle (caller guarantees space or a same-cycle pop)
//   pop    : discard the head word this cycle (caller guarantees level != 0)
//   flush  : synchronous empty; a push in the same cycle lands in slot 0
//   din    : word to write
//   head   : word at the read pointer, combinational
//   level  : number of stored words, 0..DEPTH
module word_fifo
    import rgb565_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WORD_W-1:0]        din,
    output logic [WORD_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_addr;

    // A flush restarts the write pointer at 0, so a coincident push must land there.
    assign wr_addr = flush ? '0 : wr_ptr;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; a slot is only ever read after being written,
    // as level gates everything downstream, so clearing it would buy nothing.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_addr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PTR_W'(1) : '0;
            level  <= push ? LEVEL_W'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rgb565_pixel_serializer.sv
// rgb565_pixel_serializer: buffers two-pixel RGB565 words and emits one RGB888
// pixel per valid/ready handshake, low half of each word first.
//   clock       : clock for all state
//   reset       : asynchronous, active-high
//   rgb         : {second pixel, first pixel}, RGB565 each
//   rgb_enable  : rgb valid this cycle; no backpressure, dropped if no room
//   flush       : synchronous clear of FIFO and half select (overflow kept)
//   pixel       : {R8, G8, B8} of the current pixel, 0 when not valid
//   pixel_valid : a pixel is presented (FIFO not empty)
//   pixel_ready : consumer accepts pixel this cycle
//   level       : words held in the FIFO
//   overflow    : sticky drop flag, cleared only by reset
module rgb565_pixel_serializer
    import rgb565_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WORD_W-1:0]        rgb,
    input  logic                     rgb_enable,
    input  logic                     flush,
    output logic [PIXEL_W-1:0]       pixel,
    output logic                     pixel_valid,
    input  logic                     pixel_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int LEVEL_W = $clog2(DEPTH) + 1;
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

    logic              half;
    logic              transfer;
    logic              pop;
    logic              accept;
    logic              drop;
    logic [WORD_W-1:0] head;
    rgb565_t           cur_565;

    assign pixel_valid = (level != '0);
    assign transfer    = pixel_valid && pixel_ready;
    // Flush cancels the pop; the emptied FIFO has room for the write anyway.
    assign pop         = transfer && half && !flush;
    assign accept      = rgb_enable && (flush || (level != FULL_LEVEL) || pop);
    assign drop        = rgb_enable && !accept;

    word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .flush (flush),
        .din   (rgb),
        .head  (head),
        .level (level)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cur_565 = head[15:0];
        pixel   = '0;
        if (half) cur_565 = head[31:16];
        if (pixel_valid) pixel = expand565(cur_565);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            half     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                half <= 1'b0;
            end else if (transfer) begin
                half <= ~half;
            end
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rgb565_pixel_serializer.sv
// tb_rgb565_pixel_serializer: directed bench for rgb565_pixel_serializer
// with DEPTH = 4. Inputs change on the falling edge; outputs are compared on
// the falling edge after the rising edge that updated them.
module tb_rgb565_pixel_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rgb;
    logic        rgb_enable;
    logic        flush;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [2:0]  level;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    rgb565_pixel_serializer #(.DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .rgb         (rgb),
        .rgb_enable  (rgb_enable),
        .flush       (flush),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .level       (level),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full clock: passes a rising edge, returns at the next falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic write_word(input logic [31:0] w);
        rgb        = w;
        rgb_enable = 1'b1;
        tick();
        rgb_enable = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        rgb         = '0;
        rgb_enable  = 1'b0;
        flush       = 1'b0;
        pixel_ready = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_level", level, 0);
        check("rst_valid", pixel_valid, 0);
        check("rst_pixel", pixel, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;

        // Single word, pure green then pure red
        pixel_ready = 1'b1;
        write_word(32'hF800_07E0);
        check("w1_valid", pixel_valid, 1);
        check("w1_lo", pixel, 24'h00FF00);
        tick();
        check("w1_hi", pixel, 24'hFF0000);
        tick();
        check("w1_empty_valid", pixel_valid, 0);
        check("w1_empty_level", level, 0);
        check("w1_empty_pixel", pixel, 0);

        // Mid-grey and pure blue
        write_word(32'h001F_8410);
        check("w2_lo", pixel, 24'h848284);
        tick();
        check("w2_hi", pixel, 24'h0000FF);
        tick();
        check("w2_empty", pixel_valid, 0);

        // Fill to DEPTH with the consumer stalled, then overrun by one
        pixel_ready = 1'b0;
        write_word(32'h001F_F800);
        write_word(32'h07E0_0000);
        write_word(32'hFFFF_8410);
        write_word(32'h0841_4208);
        check("full_level", level, 4);
        check("full_no_ovf", overflow, 0);
        check("stall_hold", pixel, 24'hFF0000);
        write_word(32'hAAAA_5555);
        check("ovf_level", level, 4);
        check("ovf_set", overflow, 1);

        // Drain: words 1-4 only, low half then high half
        pixel_ready = 1'b1;
        check("drain0", pixel, 24'hFF0000); tick();
        check("drain1", pixel, 24'h0000FF); tick();
        check("drain2", pixel, 24'h000000); tick();
        check("drain3", pixel, 24'h00FF00); tick();
        check("drain4", pixel, 24'h848284); tick();
        check("drain5", pixel, 24'hFFFFFF); tick();
        check("drain6", pixel, 24'h424142); tick();
        check("drain7", pixel, 24'h080808); tick();
        check("drain_empty", pixel_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Full FIFO: write accepted when the high half pops in the same cycle
        pixel_ready = 1'b0;
        do_reset();
        check("rst2_overflow", overflow, 0);
        write_word(32'h001F_F800);
        write_word(32'h07E0_0000);
        write_word(32'hFFFF_8410);
        write_word(32'h0841_4208);
        pixel_ready = 1'b1;
        tick();
        check("fp_hi", pixel, 24'h0000FF);
        write_word(32'hAAAA_5555);
        check("fp_level", level, 4);
        check("fp_no_ovf", overflow, 0);
        check("fp_next", pixel, 24'h000000);

        // Reach half = 1 with level = 3, then flush with a write
        tick();
        tick();
        check("pre_flush_level", level, 3);
        tick();
        check("pre_flush_hi", pixel, 24'hFFFFFF);
        flush = 1'b1;
        write_word(32'h07E0_F800);
        flush       = 1'b0;
        pixel_ready = 1'b0;
        check("flush_level", level, 1);
        check("flush_lo", pixel, 24'hFF0000);
        check("flush_ovf", overflow, 0);
        pixel_ready = 1'b1;
        tick();
        check("flush_hi", pixel, 24'h00FF00);
        pixel_ready = 1'b0;

        // Build up state and an overflow, then reset between clock edges
        write_word(32'h1111_2222);
        write_word(32'h3333_4444);
        write_word(32'h5555_6666);
        write_word(32'h7777_8888);
        check("pre_arst_level", level, 4);
        check("pre_arst_ovf", overflow, 1);
        pixel_ready = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("arst_valid", pixel_valid, 0);
        check("arst_level", level, 0);
        check("arst_ovf", overflow, 0);
        check("arst_pixel", pixel, 0);
        tick();
        reset = 1'b0;

        // Clean operation after the asynchronous reset
        write_word(32'hF800_001F);
        check("post_arst_lo", pixel, 24'h0000FF);
        tick();
        check("post_arst_hi", pixel, 24'hFF0000);
        tick();
        check("post_arst_empty", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
